// File: rtl/bnn_weight_streamer.sv
// Streams a 12-entry weight buffer to the BNN core as qualified nibble pairs (low, then high).
// All outputs are registered so the core sees glitch-free load_en/uio_in[7:4].
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 12,
  parameter int GAP_CYCLES  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       hold,
  output logic       load_en,
  output logic [3:0] weight_nib,
  output logic [3:0] neuron_idx,
  output logic       busy,
  output logic       done,
  output logic       wr_err
);

  localparam int         GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [3:0] LAST = 4'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {IDLE, LO, HI, GAP, DONE} state_t;

  state_t          state, state_n;
  logic [3:0]      idx, idx_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;
  logic [7:0]      weights [NUM_NEURONS];
  logic            load_en_n, done_n, wr_ok, wr_err_n;
  logic [3:0]      nib_n;

  // Must match the core's own reset weights so both sides agree after a shared reset.
  function automatic logic [7:0] default_weight(input int i);
    case (i)
      0:  return 8'hA0;
      1:  return 8'h41;
      2:  return 8'h7A;
      3:  return 8'h18;
      4:  return 8'hED;
      5:  return 8'hB7;
      6:  return 8'h67;
      7:  return 8'h3A;
      8:  return 8'hF9;
      9:  return 8'h62;
      10: return 8'hF7;
      11: return 8'h0F;
      default: return 8'h00;
    endcase
  endfunction

  assign wr_ok    = (state == IDLE) && wr_en && (int'(wr_addr) < NUM_NEURONS);
  assign wr_err_n = wr_en && !wr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) weights[i] <= default_weight(i);
    end else if (wr_ok) begin
      weights[wr_addr] <= wr_data;
    end
  end

  // The start edge itself issues the first low nibble, giving one-cycle start latency.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    gap_cnt_n = gap_cnt;
    load_en_n = 1'b0;
    nib_n     = 4'h0;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !wr_en) begin
          idx_n = 4'd0;
          if (hold) begin
            state_n = LO;
          end else begin
            load_en_n = 1'b1;
            nib_n     = weights[0][3:0];
            state_n   = HI;
          end
        end
      end
      LO: begin
        if (!hold) begin
          load_en_n = 1'b1;
          nib_n     = weights[idx][3:0];
          state_n   = HI;
        end
      end
      HI: begin
        if (!hold) begin
          load_en_n = 1'b1;
          nib_n     = weights[idx][7:4];
          if (idx == LAST) begin
            state_n = DONE;
          end else if (GAP_CYCLES > 0) begin
            gap_cnt_n = '0;
            state_n   = GAP;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = LO;
          end
        end
      end
      GAP: begin
        if (int'(gap_cnt) == GAP_CYCLES - 1) begin
          idx_n   = idx + 4'd1;
          state_n = LO;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        idx_n   = 4'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 4'd0;
      gap_cnt    <= '0;
      load_en    <= 1'b0;
      weight_nib <= 4'h0;
      neuron_idx <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      gap_cnt    <= gap_cnt_n;
      load_en    <= load_en_n;
      weight_nib <= nib_n;
      // Report the neuron whose nibble is on the wire, not the one queued next.
      neuron_idx <= (state_n == IDLE) ? 4'd0 : idx;
      busy       <= (state_n != IDLE);
      done       <= done_n;
      wr_err     <= wr_err_n;
    end
  end

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Bench for bnn_weight_streamer: a GAP=0 and a GAP=2 instance checked cycle by cycle
// against a queue-based model of the nibble stream.
module tb_bnn_weight_streamer;

  localparam int N    = 12;
  localparam int MAXC = 200;

  logic clk = 1'b0;
  logic reset;
  logic       wr_en0, start0, hold0, load_en0, busy0, done0, wr_err0;
  logic [3:0] wr_addr0, nib0, idx0;
  logic [7:0] wr_data0;
  logic       wr_en1, start1, hold1, load_en1, busy1, done1, wr_err1;
  logic [3:0] wr_addr1, nib1, idx1;
  logic [7:0] wr_data1;

  always #5 clk = ~clk;

  bnn_weight_streamer #(.NUM_NEURONS(N), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .start(start0), .hold(hold0), .load_en(load_en0), .weight_nib(nib0),
    .neuron_idx(idx0), .busy(busy0), .done(done0), .wr_err(wr_err0));

  bnn_weight_streamer #(.NUM_NEURONS(N), .GAP_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .hold(hold1), .load_en(load_en1), .weight_nib(nib1),
    .neuron_idx(idx1), .busy(busy1), .done(done1), .wr_err(wr_err1));

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] defaults [N] = '{8'hA0, 8'h41, 8'h7A, 8'h18, 8'hED, 8'hB7,
                               8'h67, 8'h3A, 8'hF9, 8'h62, 8'hF7, 8'h0F};
  logic [7:0] mbuf [2][N];

  logic       st_start [MAXC];
  logic       st_hold  [MAXC];
  logic       st_wr    [MAXC];
  logic [3:0] st_addr  [MAXC];
  logic [7:0] st_data  [MAXC];
  // Per-cycle word: {wr_err, busy, done, load_en, nib[3:0], idx[3:0]}
  logic [11:0] obs  [MAXC];
  logic [11:0] expv [MAXC];

  task automatic drive(input int sel, input logic s, input logic h, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    if (sel == 0) begin
      start0 = s; hold0 = h; wr_en0 = w; wr_addr0 = a; wr_data0 = d;
    end else begin
      start1 = s; hold1 = h; wr_en1 = w; wr_addr1 = a; wr_data1 = d;
    end
  endtask

  function automatic logic [11:0] sample(input int sel);
    logic le, bz, dn, er;
    logic [3:0] nb, ix;
    if (sel == 0) begin
      le = load_en0; bz = busy0; dn = done0; er = wr_err0; nb = nib0; ix = idx0;
    end else begin
      le = load_en1; bz = busy1; dn = done1; er = wr_err1; nb = nib1; ix = idx1;
    end
    if (bz && !le) ix = 4'd0;
    return {er, bz, dn, le, nb, ix};
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      st_start[k] = 1'b0; st_hold[k] = 1'b0; st_wr[k] = 1'b0;
      st_addr[k] = 4'd0;  st_data[k] = 8'd0;
      obs[k] = '0;        expv[k] = '0;
    end
    st_start[0] = 1'b1;
  endtask

  task automatic random_stim(input int hold_pct);
    clear_stim();
    for (int k = 0; k < 100; k++) st_hold[k] = ($urandom_range(99) < hold_pct);
    for (int k = 1; k < 2 * N; k++) st_start[k] = ($urandom_range(7) == 0);
    for (int k = 1; k <= 2 * N; k++) begin
      st_wr[k]   = ($urandom_range(9) == 0);
      st_addr[k] = 4'($urandom_range(15));
      st_data[k] = 8'($urandom);
    end
  endtask

  // Model: the frame is a queue of nibble and gap slots; a held nibble slot stays queued,
  // a gap slot always drains, and the edge that finds the queue empty raises done.
  task automatic build_expected(input int sel, input int gap, output int len);
    int q[$];
    bit busy_c;
    for (int n = 0; n < N; n++) begin
      q.push_back(n * 16 + int'(mbuf[sel][n][3:0]));
      q.push_back(n * 16 + int'(mbuf[sel][n][7:4]));
      if (n < N - 1) repeat (gap) q.push_back(-1);
    end
    busy_c = 1'b0;
    len    = MAXC - 1;
    for (int k = 0; k < MAXC - 1; k++) begin
      logic le, dn, bz, er;
      logic [3:0] nb, ix;
      le = 0; dn = 0; bz = 0; nb = 0; ix = 0;
      er = st_wr[k] && (busy_c || int'(st_addr[k]) >= N);
      if (q.size() > 0) begin
        bz = 1;
        if (q[0] < 0) begin
          void'(q.pop_front());
        end else if (!st_hold[k]) begin
          le = 1; nb = 4'(q[0] % 16); ix = 4'(q[0] / 16);
          void'(q.pop_front());
        end
      end else begin
        dn = 1;
      end
      expv[k + 1] = {er, bz, dn, le, nb, ix};
      busy_c = bz;
      if (dn) begin
        len = k + 1;
        break;
      end
    end
  endtask

  task automatic run_frame(input int sel, input int len);
    for (int k = 0; k < len; k++) begin
      drive(sel, st_start[k], st_hold[k], st_wr[k], st_addr[k], st_data[k]);
      @(posedge clk);
      @(negedge clk);
      obs[k + 1] = sample(sel);
    end
    drive(sel, 0, 0, 0, 4'd0, 8'd0);
  endtask

  task automatic idle_write(input logic [3:0] a, input logic [7:0] d, output logic er);
    drive(0, 0, 0, 1, a, d);
    @(posedge clk);
    @(negedge clk);
    er = wr_err0;
    drive(0, 0, 0, 0, 4'd0, 8'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 4'd0, 8'd0);
    drive(1, 0, 0, 0, 4'd0, 8'd0);
    repeat (2) @(negedge clk);
    compared += 2;
    if ({load_en0, nib0, idx0, busy0, done0, wr_err0} !== 12'd0) begin
      mismatched++;
      $display("FAIL reset_dut0: got %h want 0", {load_en0, nib0, idx0, busy0, done0, wr_err0});
    end
    if ({load_en1, nib1, idx1, busy1, done1, wr_err1} !== 12'd0) begin
      mismatched++;
      $display("FAIL reset_dut1: got %h want 0", {load_en1, nib1, idx1, busy1, done1, wr_err1});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({sample(0), sample(1)} !== 24'd0) begin
      mismatched++;
      $display("FAIL reset_release_idle: got %h want 0", {sample(0), sample(1)});
    end
    for (int i = 0; i < N; i++) begin
      mbuf[0][i] = defaults[i];
      mbuf[1][i] = defaults[i];
    end
  endtask

  task automatic test_default_frame();
    int len, cnt;
    logic [7:0] got [N];
    clear_stim();
    build_expected(0, 0, len);
    run_frame(0, len);
    for (int k = 1; k <= len; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL default_frame cycle %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
    compared++;
    if (obs[25][9] !== 1'b1) begin
      mismatched++;
      $display("FAIL default_done_cycle25: got %b want 1", obs[25][9]);
    end
    cnt = 0;
    for (int i = 0; i < N; i++) got[i] = 8'h00;
    for (int k = 1; k <= len; k++) begin
      if (obs[k][8] && cnt < 2 * N) begin
        if (cnt % 2 == 0) got[cnt / 2][3:0] = obs[k][7:4];
        else              got[cnt / 2][7:4] = obs[k][7:4];
        cnt++;
      end
    end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (got[i] !== defaults[i]) begin
        mismatched++;
        $display("FAIL core_weight[%0d]: got %h want %h", i, got[i], defaults[i]);
      end
    end
  endtask

  task automatic test_write_then_frame();
    int len;
    logic er;
    for (int j = 0; j < 3; j++) begin
      logic [3:0] a;
      logic [7:0] d;
      a = 4'($urandom_range(N - 1));
      d = 8'($urandom);
      idle_write(a, d, er);
      mbuf[0][a] = d;
      compared++;
      if (er !== 1'b0) begin
        mismatched++;
        $display("FAIL write_valid_err addr %0d: got %b want 0", a, er);
      end
    end
    idle_write(4'd3, 8'h5C, er);
    mbuf[0][3] = 8'h5C;
    compared++;
    if (er !== 1'b0) begin
      mismatched++;
      $display("FAIL write_5c_err: got %b want 0", er);
    end
    clear_stim();
    build_expected(0, 0, len);
    run_frame(0, len);
    for (int k = 1; k <= len; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL write_frame cycle %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
    compared++;
    if ({obs[7][8:4], obs[8][8:4]} !== {5'h1C, 5'h15}) begin
      mismatched++;
      $display("FAIL neuron3_nibbles: got %h want %h", {obs[7][8:4], obs[8][8:4]}, {5'h1C, 5'h15});
    end
  endtask

  task automatic test_hold();
    int len;
    clear_stim();
    st_hold[11] = 1'b1; st_hold[12] = 1'b1; st_hold[13] = 1'b1;
    build_expected(0, 0, len);
    run_frame(0, len);
    for (int k = 1; k <= len; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL hold_frame cycle %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
    compared++;
    if ({obs[15][8:0], obs[28][9]} !== {1'b1, mbuf[0][5][7:4], 4'd5, 1'b1}) begin
      mismatched++;
      $display("FAIL hold_resume_and_done: got %h want %h", {obs[15][8:0], obs[28][9]},
               {1'b1, mbuf[0][5][7:4], 4'd5, 1'b1});
    end
    random_stim(30);
    build_expected(0, 0, len);
    run_frame(0, len);
    for (int k = 1; k <= len; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL random_hold cycle %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_errors();
    int len;
    logic er;
    idle_write(4'd12, 8'hFF, er);
    compared++;
    if (er !== 1'b1) begin
      mismatched++;
      $display("FAIL wr_err_addr12: got %b want 1", er);
    end
    idle_write(4'($urandom_range(15, 13)), 8'h55, er);
    compared++;
    if (er !== 1'b1) begin
      mismatched++;
      $display("FAIL wr_err_addr_high: got %b want 1", er);
    end
    clear_stim();
    st_wr[5] = 1'b1; st_addr[5] = 4'($urandom_range(N - 1)); st_data[5] = 8'($urandom);
    build_expected(0, 0, len);
    run_frame(0, len);
    for (int k = 1; k <= len; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL busy_write cycle %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
    compared++;
    if ({obs[5][11], obs[6][11], obs[7][11]} !== 3'b010) begin
      mismatched++;
      $display("FAIL busy_write_pulse: got %b want 010", {obs[5][11], obs[6][11], obs[7][11]});
    end
  endtask

  task automatic test_reset_midframe();
    int len;
    logic er;
    for (int i = 0; i < N; i++) begin
      logic [7:0] d;
      d = 8'($urandom) ^ defaults[i] | 8'h01;
      idle_write(4'(i), d, er);
      mbuf[0][i] = d;
    end
    clear_stim();
    build_expected(0, 0, len);
    run_frame(0, 10);
    for (int k = 1; k <= 10; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL pre_reset cycle %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({load_en0, nib0, idx0, busy0, done0, wr_err0} !== 12'd0) begin
      mismatched++;
      $display("FAIL async_reset_outputs: got %h want 0", {load_en0, nib0, idx0, busy0, done0, wr_err0});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) mbuf[0][i] = defaults[i];
    clear_stim();
    build_expected(0, 0, len);
    run_frame(0, len);
    for (int k = 1; k <= len; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL post_reset_frame cycle %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_gap();
    int len;
    clear_stim();
    build_expected(1, 2, len);
    run_frame(1, len);
    for (int k = 1; k <= len; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL gap_frame cycle %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
    compared++;
    if ({obs[46][10:8], obs[47][10:8]} !== {3'b101, 3'b010}) begin
      mismatched++;
      $display("FAIL gap_done_cycle47: got %b want 101010", {obs[46][10:8], obs[47][10:8]});
    end
    random_stim(25);
    build_expected(1, 2, len);
    run_frame(1, len);
    for (int k = 1; k <= len; k++) begin
      compared++;
      if (obs[k] !== expv[k]) begin
        mismatched++;
        $display("FAIL gap_random cycle %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int len;
    for (int f = 0; f < 3; f++) begin
      random_stim(20);
      build_expected(0, 0, len);
      run_frame(0, len);
      for (int k = 1; k <= len; k++) begin
        compared++;
        if (obs[k] !== expv[k]) begin
          mismatched++;
          $display("FAIL back_to_back frame %0d cycle %0d: got %h want %h", f, k, obs[k], expv[k]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_default_frame();
    test_write_then_frame();
    test_hold();
    test_errors();
    test_reset_midframe();
    test_gap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
